hls_fpx_mul_pipe: RTL

Parametrised, pipelined floating-point multiplier for the NVDLA datapath. It is the successor to the fixed fp32 multiplier and is generalised in exponent and mantissa width. It has a three-stage pipeline with full back-pressure, and round-to-nearest-even arithmetic. It keeps the same two-input, one-output channel handshake (`_rsc_z` / `_rsc_vz` / `_rsc_lz`), so it drops into the existing HLS math wrappers.

---
 rtl/hls_fpx_mul_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hls_fpx_mul_pipe.sv
// hls_fpx_mul_pipe: 3-stage parametrised FP multiplier, RNE, flush-to-zero, global-stall back-pressure.
// Define FPX_MUL_NAN_CANON_EN to force every NaN result to the canonical quiet NaN.
module hls_fpx_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic [EXP_W+MAN_W:0]   chn_a_rsc_z,
  input  logic                   chn_a_rsc_vz,
  output logic                   chn_a_rsc_lz,
  input  logic [EXP_W+MAN_W:0]   chn_b_rsc_z,
  input  logic                   chn_b_rsc_vz,
  output logic                   chn_b_rsc_lz,
  output logic [EXP_W+MAN_W:0]   chn_o_rsc_z,
  input  logic                   chn_o_rsc_vz,
  output logic                   chn_o_rsc_lz
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * (MAN_W + 1);
  localparam logic [EXP_W-1:0]     EMAX  = '1;
  localparam logic [MAN_W-1:0]     QBIT  = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [EW-1:0] EINF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  logic                   w_stall, w_acc;
  logic                   w_sa, w_sb, w_s;
  logic [EXP_W-1:0]       w_ea, w_eb;
  logic [MAN_W-1:0]       w_ma, w_mb;
  logic                   w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_nan, w_spec;
  logic [W-1:0]           w_canon, w_nan_z, w_spec_z;
  logic signed [EW-1:0]   w_esum;

  logic                   r1_v, r1_s, r1_spec;
  logic signed [EW-1:0]   r1_e;
  logic [MAN_W-1:0]       r1_ma, r1_mb;
  logic [W-1:0]           r1_spec_z;

  logic                   r2_v, r2_s, r2_spec;
  logic signed [EW-1:0]   r2_e;
  logic [PW-1:0]          r2_p;
  logic [W-1:0]           r2_spec_z;

  logic                   w_hi, w_grd, w_stk;
  logic [MAN_W-1:0]       w_man;
  logic [MAN_W:0]         w_man_r;
  logic signed [EW-1:0]   w_e_n;
  logic [W-1:0]           w_res;

  assign w_stall      = chn_o_rsc_lz & ~chn_o_rsc_vz;
  assign w_acc        = chn_a_rsc_vz & chn_b_rsc_vz & ~w_stall;
  assign chn_a_rsc_lz = w_acc;
  assign chn_b_rsc_lz = w_acc;

  assign {w_sa, w_ea, w_ma} = chn_a_rsc_z;
  assign {w_sb, w_eb, w_mb} = chn_b_rsc_z;
  assign w_s      = w_sa ^ w_sb;
  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EMAX) && (w_ma == '0);
  assign w_b_inf  = (w_eb == EMAX) && (w_mb == '0);
  assign w_a_nan  = (w_ea == EMAX) && (w_ma != '0);
  assign w_b_nan  = (w_eb == EMAX) && (w_mb != '0);
  assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_spec   = w_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_canon  = {1'b0, EMAX, QBIT};
`ifdef FPX_MUL_NAN_CANON_EN
  assign w_nan_z  = w_canon;
`else
  assign w_nan_z  = w_a_nan ? {w_sa, EMAX, w_ma | QBIT} :
                    w_b_nan ? {w_sb, EMAX, w_mb | QBIT} : w_canon;
`endif
  assign w_spec_z = w_nan ? w_nan_z :
                    (w_a_inf | w_b_inf) ? {w_s, EMAX, {MAN_W{1'b0}}} : {w_s, {(W-1){1'b0}}};
  assign w_esum   = EW'(w_ea) + EW'(w_eb) - BIAS;

  // product lies in [1,4): MSB set means one extra integer bit to shift out
  assign w_hi    = r2_p[PW-1];
  assign w_man   = w_hi ? r2_p[PW-2 -: MAN_W] : r2_p[PW-3 -: MAN_W];
  assign w_grd   = w_hi ? r2_p[MAN_W] : r2_p[MAN_W-1];
  assign w_stk   = w_hi ? |r2_p[MAN_W-1:0] : |r2_p[MAN_W-2:0];
  assign w_man_r = {1'b0, w_man} + {{MAN_W{1'b0}}, w_grd & (w_stk | w_man[0])};
  assign w_e_n   = r2_e + EW'(w_hi) + EW'(w_man_r[MAN_W]);
  assign w_res   = r2_spec ? r2_spec_z :
                   (w_e_n >= EINF)  ? {r2_s, EMAX, {MAN_W{1'b0}}} :
                   (w_e_n <= EZERO) ? {r2_s, {(W-1){1'b0}}} :
                   {r2_s, w_e_n[EXP_W-1:0], w_man_r[MAN_W-1:0]};

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r1_v         <= 1'b0;
      r1_s         <= 1'b0;
      r1_spec      <= 1'b0;
      r1_e         <= '0;
      r1_ma        <= '0;
      r1_mb        <= '0;
      r1_spec_z    <= '0;
      r2_v         <= 1'b0;
      r2_s         <= 1'b0;
      r2_spec      <= 1'b0;
      r2_e         <= '0;
      r2_p         <= '0;
      r2_spec_z    <= '0;
      chn_o_rsc_lz <= 1'b0;
      chn_o_rsc_z  <= '0;
    end else if (!w_stall) begin
      r1_v         <= w_acc;
      r1_s         <= w_s;
      r1_spec      <= w_spec;
      r1_e         <= w_esum;
      r1_ma        <= w_ma;
      r1_mb        <= w_mb;
      r1_spec_z    <= w_spec_z;
      r2_v         <= r1_v;
      r2_s         <= r1_s;
      r2_spec      <= r1_spec;
      r2_e         <= r1_e;
      r2_p         <= PW'({1'b1, r1_ma}) * PW'({1'b1, r1_mb});
      r2_spec_z    <= r1_spec_z;
      chn_o_rsc_lz <= r2_v;
      chn_o_rsc_z  <= w_res;
    end
  end
endmodule
